// File: rtl/lcm_calc.sv
// lcm_calc: least common multiple of (a, b) given g = gcd(a, b).
// Computes (a / g) * b with a restoring divider and a shift-add multiplier.
//
// Ports:
//   sys_clk    : clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   in_valid   : operand triple a/b/g is valid
//   in_ready   : block can accept a triple (high only in IDLE)
//   a, b       : operands (WIDTH bits, unsigned)
//   g          : gcd of a and b as produced by the gcd core
//   out_valid  : lcm_val/err are valid (held until out_ready)
//   out_ready  : consumer takes the result
//   lcm_val    : least common multiple (2*WIDTH bits)
//   err        : g == 0 or g does not divide a

module lcm_calc #(
    parameter int WIDTH = 32
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   g,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] lcm_val,
    output logic               err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        MUL,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    // Dividend shifts out of the top while quotient bits shift in at the
    // bottom, so after WIDTH steps this register holds the quotient.
    logic [WIDTH-1:0]   dq_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   g_r;
    logic [WIDTH:0]     rem;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    // Set when g leaves a nonzero remainder; the MUL window then runs
    // with accumulation suppressed so latency is unchanged.
    logic               bad;

    logic               accept;
    logic               short_zero;
    logic               short_err;
    logic               last;
    logic [WIDTH+1:0]   rem_sh;
    logic               rem_ge;
    logic [WIDTH+1:0]   rem_nx;
    logic               div_ok;
    logic [WIDTH-1:0]   quo_nx;
    logic [2*WIDTH-1:0] acc_nx;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    always_comb begin
        accept     = in_valid && (state == IDLE);
        short_zero = ((a == '0) || (b == '0)) && (g != '0);
        short_err  = (g == '0);
        last       = (cnt == CW'(1));

        // One restoring-division step.
        rem_sh = {rem, dq_r[WIDTH-1]};
        rem_ge = (rem_sh >= {2'b00, g_r});
        rem_nx = rem_ge ? (rem_sh - {2'b00, g_r}) : rem_sh;
        div_ok = (rem_nx == '0);
        quo_nx = {dq_r[WIDTH-2:0], rem_ge};

        // One shift-add multiply step.
        acc_nx = (mplier[0] && !bad) ? (acc + mcand) : acc;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (short_zero || short_err) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = DIV;
                    end
                end
            end
            DIV: begin
                if (last) begin
                    state_nx = MUL;
                end
            end
            MUL: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dq_r    <= '0;
            b_r     <= '0;
            g_r     <= '0;
            rem     <= '0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            bad     <= 1'b0;
            lcm_val <= '0;
            err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        dq_r   <= a;
                        b_r    <= b;
                        g_r    <= g;
                        rem    <= '0;
                        cnt    <= CW'(WIDTH);
                        acc    <= '0;
                        mcand  <= '0;
                        mplier <= '0;
                        bad    <= 1'b0;
                        if (short_zero) begin
                            lcm_val <= '0;
                            err     <= 1'b0;
                        end else if (short_err) begin
                            lcm_val <= '0;
                            err     <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    dq_r <= quo_nx;
                    rem  <= rem_nx[WIDTH:0];
                    if (last) begin
                        cnt    <= CW'(WIDTH);
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, b_r};
                        mplier <= quo_nx;
                        bad    <= !div_ok;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                MUL: begin
                    acc    <= acc_nx;
                    mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    if (last) begin
                        cnt     <= '0;
                        lcm_val <= bad ? '0 : acc_nx;
                        err     <= bad;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_calc.sv
// tb_lcm_calc: scoreboard bench for lcm_calc (WIDTH = 32).
// Expected results come from a behavioural model at accept time.

module tb_lcm_calc;

    localparam int W = 32;
    localparam int LIM = 200;

    logic           sys_clk   = 1'b0;
    logic           sys_rst_n = 1'b0;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [W-1:0]   g = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] lcm_val;
    logic           err;

    typedef struct {
        logic [2*W-1:0] lcm;
        logic           err;
        int             lat;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_bad = 0;
    longint unsigned cyc = 0;

    lcm_calc #(.WIDTH(W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lcm_val   (lcm_val),
        .err       (err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Latency is counted in clock edges after the accept edge.
    function automatic exp_t model(input logic [W-1:0] av,
                                   input logic [W-1:0] bv,
                                   input logic [W-1:0] gv);
        exp_t e;
        logic [2*W-1:0] q;
        logic [2*W-1:0] bb;
        e.lcm = '0;
        e.err = 1'b0;
        e.lat = 2 * W;
        if ((av == 0 || bv == 0) && gv != 0) begin
            e.lat = 0;
        end else if (gv == 0) begin
            e.err = 1'b1;
            e.lat = 0;
        end else if ((av % gv) != 0) begin
            e.err = 1'b1;
        end else begin
            q = {{W{1'b0}}, av / gv};
            bb = {{W{1'b0}}, bv};
            e.lcm = q * bb;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic [W-1:0] p = x;
        logic [W-1:0] r = y;
        logic [W-1:0] t;
        while (r != 0) begin
            t = p % r;
            p = r;
            r = t;
        end
        return p;
    endfunction

    // Called #1 after a rising edge with in_ready high; returns #1 after
    // the accept edge with t holding the cycle stamp of that edge.
    task automatic accept(input logic [W-1:0] av,
                          input logic [W-1:0] bv,
                          input logic [W-1:0] gv,
                          output longint unsigned t);
        a = av;
        b = bv;
        g = gv;
        in_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        t = cyc;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        g = $urandom;
        sb.push_back(model(av, bv, gv));
    endtask

    task automatic wait_valid(output int n, output bit seen);
        n = 0;
        seen = out_valid;
        while (!seen && n < LIM) begin
            @(posedge sys_clk);
            #1;
            n++;
            seen = out_valid;
        end
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        #3;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset in_ready got %b exp 1", in_ready);
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset out_valid got %b exp 0", out_valid);
        end
        n_vec++;
        if (lcm_val !== '0) begin
            n_bad++;
            $display("FAIL reset lcm_val got %h exp 0", lcm_val);
        end
        n_vec++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset err got %b exp 0", err);
        end
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_basic;
        logic [W-1:0] tv[5][3];
        longint unsigned t;
        int n;
        bit seen;
        exp_t e;
        tv[0] = '{32'd12, 32'd18, 32'd6};
        tv[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
        tv[2] = '{32'd4, 32'd6, 32'd2};
        tv[3] = '{32'd1, 32'd1, 32'd1};
        tv[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            accept(tv[i][0], tv[i][1], tv[i][2], t);
            wait_valid(n, seen);
            e = sb.pop_front();
            n_vec++;
            if (!seen) begin
                n_bad++;
                $display("FAIL basic[%0d] timeout: no out_valid in %0d", i, LIM);
            end
            n_vec++;
            if (n != e.lat) begin
                n_bad++;
                $display("FAIL basic[%0d] latency got %0d exp %0d", i, n, e.lat);
            end
            n_vec++;
            if (lcm_val !== e.lcm || err !== e.err) begin
                n_bad++;
                $display("FAIL basic[%0d] result got %h/%b exp %h/%b",
                         i, lcm_val, err, e.lcm, e.err);
            end
            out_ready = 1'b1;
            @(posedge sys_clk);
            #1;
            out_ready = 1'b0;
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL basic[%0d] drain got ov=%b ir=%b exp 0/1",
                         i, out_valid, in_ready);
            end
        end
        // Spot check against the literal expected product.
        n_vec++;
        if (model(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1).lcm
            !== 64'hFFFF_FFFD_0000_0002) begin
            n_bad++;
            $display("FAIL max model got %h exp fffffffd00000002",
                     model(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1).lcm);
        end
    endtask

    task automatic test_short_circuit;
        logic [W-1:0] tv[4][3];
        longint unsigned t;
        int n;
        bit seen;
        exp_t e;
        tv[0] = '{32'd0, 32'd5, 32'd5};
        tv[1] = '{32'd7, 32'd3, 32'd0};
        tv[2] = '{32'd9, 32'd0, 32'd9};
        tv[3] = '{32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 4; i++) begin
            accept(tv[i][0], tv[i][1], tv[i][2], t);
            wait_valid(n, seen);
            e = sb.pop_front();
            n_vec++;
            if (!seen || n != e.lat) begin
                n_bad++;
                $display("FAIL short[%0d] latency got %0d (seen %b) exp %0d",
                         i, n, seen, e.lat);
            end
            n_vec++;
            if (lcm_val !== e.lcm || err !== e.err) begin
                n_bad++;
                $display("FAIL short[%0d] result got %h/%b exp %h/%b",
                         i, lcm_val, err, e.lcm, e.err);
            end
            out_ready = 1'b1;
            @(posedge sys_clk);
            #1;
            out_ready = 1'b0;
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL short[%0d] drain got ov=%b ir=%b exp 0/1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_bad_gcd;
        logic [W-1:0] tv[3][3];
        longint unsigned t;
        int n;
        bit seen;
        exp_t e;
        tv[0] = '{32'd10, 32'd4, 32'd3};
        tv[1] = '{32'd7, 32'd5, 32'd2};
        tv[2] = '{32'd5, 32'd5, 32'd10};
        for (int i = 0; i < 3; i++) begin
            accept(tv[i][0], tv[i][1], tv[i][2], t);
            wait_valid(n, seen);
            e = sb.pop_front();
            n_vec++;
            if (!seen || n != e.lat) begin
                n_bad++;
                $display("FAIL badg[%0d] latency got %0d (seen %b) exp %0d",
                         i, n, seen, e.lat);
            end
            n_vec++;
            if (lcm_val !== e.lcm || err !== e.err) begin
                n_bad++;
                $display("FAIL badg[%0d] result got %h/%b exp %h/%b",
                         i, lcm_val, err, e.lcm, e.err);
            end
            out_ready = 1'b1;
            @(posedge sys_clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_back_pressure;
        longint unsigned t;
        int n;
        bit seen;
        bit ok;
        exp_t e;
        accept(32'd21, 32'd6, 32'd3, t);
        ok = 1'b1;
        repeat (5) begin
            a = 32'd1;
            b = 32'd1;
            g = 32'd1;
            in_valid = 1'b1;
            if (in_ready !== 1'b0) ok = 1'b0;
            @(posedge sys_clk);
            #1;
        end
        in_valid = 1'b0;
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL bp busy in_ready got 1 exp 0");
        end
        wait_valid(n, seen);
        e = sb.pop_front();
        n_vec++;
        if (!seen || n + 5 != e.lat) begin
            n_bad++;
            $display("FAIL bp latency got %0d (seen %b) exp %0d",
                     n + 5, seen, e.lat);
        end
        n_vec++;
        if (lcm_val !== 64'd42 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL bp result got %h/%b exp 2a/0", lcm_val, err);
        end
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i < 18);
            @(posedge sys_clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                lcm_val !== 64'd42 || err !== 1'b0) ok = 1'b0;
        end
        in_valid = 1'b0;
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL bp hold got ov=%b ir=%b lcm=%h exp 1/0/2a",
                     out_valid, in_ready, lcm_val);
        end
        out_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp release got ov=%b ir=%b exp 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run;
        longint unsigned t;
        int n;
        bit seen;
        bit ok;
        exp_t e;
        accept(32'd12, 32'd18, 32'd6, t);
        void'(sb.pop_back());
        repeat (10) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            lcm_val !== '0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid outputs got ir=%b ov=%b lcm=%h err=%b exp 1/0/0/0",
                     in_ready, out_valid, lcm_val, err);
        end
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        ok = 1'b1;
        repeat (70) begin
            @(posedge sys_clk);
            #1;
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rst_mid spurious out_valid got 1 exp 0");
        end
        accept(32'd4, 32'd6, 32'd2, t);
        wait_valid(n, seen);
        e = sb.pop_front();
        n_vec++;
        if (!seen || n != e.lat || lcm_val !== 64'd12 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid rerun got lat=%0d lcm=%h err=%b exp %0d/c/0",
                     n, lcm_val, err, e.lat);
        end
        out_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        longint unsigned t;
        longint unsigned t_prev;
        int n;
        int gap_exp;
        bit seen;
        exp_t e;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] gv;
        out_ready = 1'b1;
        t_prev = 0;
        gap_exp = 0;
        for (int i = 0; i < 6; i++) begin
            av = $urandom_range(1, 100000) * $urandom_range(1, 300);
            bv = $urandom_range(1, 100000) * $urandom_range(1, 300);
            gv = gcd_f(av, bv);
            if (i == 2) gv = gv + 1;
            if (i == 4) av = 0;
            accept(av, bv, gv, t);
            if (i > 0) begin
                n_vec++;
                if (t - t_prev != longint'(gap_exp)) begin
                    n_bad++;
                    $display("FAIL b2b[%0d] accept spacing got %0d exp %0d",
                             i, t - t_prev, gap_exp);
                end
            end
            t_prev = t;
            wait_valid(n, seen);
            e = sb.pop_front();
            gap_exp = e.lat + 2;
            n_vec++;
            if (!seen || n != e.lat || lcm_val !== e.lcm || err !== e.err) begin
                n_bad++;
                $display("FAIL b2b[%0d] got lat=%0d lcm=%h err=%b exp %0d/%h/%b",
                         i, n, lcm_val, err, e.lat, e.lcm, e.err);
            end
            @(posedge sys_clk);
            #1;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_circuit();
        test_bad_gcd();
        test_back_pressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
